fetch_unit: RTL and testbench

Instruction-fetch stage of the 16-bit MIPS pipeline, the consumer side of the stall protocol. It owns the program counter and the instruction register (IR). It presents the IR opcode to the stall controller and obeys the returned `stall` / `stall_pm` pair by holding, bubbling or advancing. It also applies jump redirects from execute and latches the halted condition.

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, obeys the stall/stall_pm handshake,
// applies jump redirects from execute and latches a sticky halt.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP      = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        stall_pm,
  input  logic        jump_en,
  input  logic [15:0] jump_target,
  input  logic [15:0] pm_data,
  output logic [15:0] pm_addr,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [5:0]  op,
  output logic        dec_valid,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  localparam logic [5:0] OP_HLT = 6'b010001;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] pc_r, pc_s;
  logic [15:0] ir_r, ir_s;
  logic        ir_valid_r, ir_valid_s;
  logic        halted_r;
  logic [15:0] cnt_r, cnt_s;
  logic        dec_valid_s;
  logic [5:0]  op_s;

  assign op_s        = ir_r[15:10];
  assign dec_valid_s = ir_valid_r & ~stall_pm & ~halted_r;

  assign pm_addr      = pc_r;
  assign pc           = pc_r;
  assign ir           = ir_r;
  assign op           = op_s;
  assign dec_valid    = dec_valid_s;
  assign halted       = halted_r;
  assign stall_cycles = cnt_r;

  // Next-state logic: halt entry outranks a same-cycle jump, jump outranks stall.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    ir_s       = ir_r;
    ir_valid_s = ir_valid_r;
    cnt_s      = cnt_r;
    case (state_r)
      ST_RUN: begin
        if (stall && (cnt_r != 16'hFFFF)) begin
          cnt_s = cnt_r + 16'h0001;
        end else begin
          cnt_s = cnt_r;
        end
        if (dec_valid_s && (op_s == OP_HLT)) begin
          state_s = ST_HALTED;
        end else if (jump_en) begin
          pc_s       = jump_target;
          ir_s       = NOP;
          ir_valid_s = 1'b0;
        end else if (stall) begin
          pc_s       = pc_r;
          ir_s       = ir_r;
          ir_valid_s = ir_valid_r;
        end else begin
          ir_s       = pm_data;
          ir_valid_s = 1'b1;
          pc_s       = pc_r + 16'h0001;
        end
      end
      ST_HALTED: begin
        state_s = ST_HALTED;
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // State and datapath registers; reset dominates every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_RUN;
      pc_r       <= RESET_PC;
      ir_r       <= NOP;
      ir_valid_r <= 1'b0;
      halted_r   <= 1'b0;
      cnt_r      <= 16'h0000;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      ir_r       <= ir_s;
      ir_valid_r <= ir_valid_s;
      halted_r   <= (state_s == ST_HALTED);
      cnt_r      <= cnt_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a bench-side model pushes expected register
// state per driven cycle; the entry is popped and compared after the edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, stall_pm, jump_en;
  logic [15:0] jump_target, pm_data, pm_addr, pc, ir, stall_cycles;
  logic [5:0]  op;
  logic        dec_valid, halted;

  logic [15:0] mem [0:65535];

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
    logic        hlt;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  // model state
  logic [15:0] m_pc, m_ir, m_cnt;
  logic        m_v, m_halt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign pm_data = mem[pm_addr];

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .stall_pm(stall_pm),
    .jump_en(jump_en), .jump_target(jump_target), .pm_data(pm_data),
    .pm_addr(pm_addr), .pc(pc), .ir(ir), .op(op), .dec_valid(dec_valid),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, model, push, edge, pop, compare.
  task automatic step(input logic s, input logic spm, input logic j,
                      input logic [15:0] t, input logic r = 1'b0, input bit full = 1'b1);
    logic dv;
    exp_t e;
    @(negedge clk);
    reset = r; stall = s; stall_pm = spm; jump_en = j; jump_target = t;
    #1;
    dv = m_v & ~spm & ~m_halt;
    if (full) begin
      check_eq("dec_valid", {15'd0, dec_valid}, {15'd0, dv});
      check_eq("pm_addr", pm_addr, m_pc);
      check_eq("op", {10'd0, op}, {10'd0, m_ir[15:10]});
    end
    if (r) begin
      m_pc = 16'h0000; m_ir = 16'h0000; m_v = 1'b0; m_halt = 1'b0; m_cnt = 16'h0000;
    end else if (!m_halt) begin
      if (s && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (dv && m_ir[15:10] == 6'b010001) m_halt = 1'b1;
      else if (j) begin m_pc = t; m_ir = 16'h0000; m_v = 1'b0; end
      else if (!s) begin m_ir = mem[m_pc]; m_v = 1'b1; m_pc = m_pc + 16'd1; end
    end
    sb.push_back('{pc: m_pc, ir: m_ir, hlt: m_halt, cnt: m_cnt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (full || r) begin
      check_eq("pc", pc, e.pc);
      check_eq("ir", ir, e.ir);
      check_eq("halted", {15'd0, halted}, {15'd0, e.hlt});
      check_eq("stall_cycles", stall_cycles, e.cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0400; mem[1] = 16'h0800; mem[2] = 16'h0C00;
    mem[3] = 16'h5000; mem[4] = 16'h0400;
    mem[5] = 16'h7000; mem[16'h0040] = 16'h0800; mem[16'h0041] = 16'h4400;
    reset = 1'b1; stall = 1'b0; stall_pm = 1'b0; jump_en = 1'b0; jump_target = 16'h0000;
    m_pc = 16'hxxxx; m_ir = 16'hxxxx; m_v = 1'b0; m_halt = 1'b0; m_cnt = 16'hxxxx;

    // reset and straight-line fetch
    step(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("rst_pc", pc, 16'h0000);
    check_eq("rst_dec_valid", {15'd0, dec_valid}, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("sl_ir0", ir, 16'h0400);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("sl_pc3", pc, 16'h0003);
    check_eq("sl_ir2", ir, 16'h0C00);

    // LOAD: one issue cycle under stall, then a bubble while IR advances
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("ld_ir", ir, 16'h5000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("ld_pc_hold", pc, 16'h0004);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    check_eq("ld_next_ir", ir, 16'h0400);
    check_eq("ld_stall_cycles", stall_cycles, 16'h0001);

    // JUMP: two stall cycles, redirect on the second
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("jmp_ir", ir, 16'h7000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'h0040);
    check_eq("jmp_pc", pc, 16'h0040);
    check_eq("jmp_nop", ir, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    check_eq("jmp_resume", pc, 16'h0041);

    // Halt: HLT issues, jump in the same cycle is ignored, then frozen
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("hlt_ir", ir, 16'h4400);
    step(1'b0, 1'b0, 1'b1, 16'h1234);
    check_eq("hlt_flag", {15'd0, halted}, 16'h0001);
    check_eq("hlt_pc", pc, 16'h0042);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 16'h2222);
    check_eq("hlt_cnt_frozen", stall_cycles, 16'h0003);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("hlt_reset", {15'd0, halted}, 16'h0000);

    // PC wrap
    step(1'b0, 1'b0, 1'b1, 16'hFFFF);
    check_eq("wrap_pre", pc, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("wrap_post", pc, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);

    // saturation, then reset in the middle of a stall
    for (int i = 0; i < 70000; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, (i % 1024) == 0);
    check_eq("sat_cnt", stall_cycles, 16'hFFFF);
    step(1'b1, 1'b1, 1'b1, 16'h5555, 1'b1);
    check_eq("mid_rst_cnt", stall_cycles, 16'h0000);
    check_eq("mid_rst_pc", pc, 16'h0000);
    check_eq("mid_rst_ir", ir, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
